shape_render_sched: RTL and testbench
=====================================

Name: shape_render_sched

Overview:
- Sequences a bank of N_PIECES render_shape instances for one video frame.
- Generates the raster scan counters and the newframe/newline strobes. Holds double-buffered per-piece geometry: a shadow bank written by game logic and an active bank that drives the shapes.
- Resolves per-pixel piece coverage into a registered piece ID for the pixel/colour stage.
- Sits between the game/state logic (config writer) and the VGA output path.

Parameters:
- N_PIECES, 7, number of render_shape instances; IDW = $clog2(N_PIECES+1).
- H_ACTIVE, 640, visible pixels per line.
- H_TOTAL, 800, clocks per line including blanking.
- V_ACTIVE, 480, visible lines per frame.
- V_TOTAL, 525, lines per frame including blanking.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  write one piece's geometry into the shadow bank.
- cfg_idx  in  IDW  piece index; writes with cfg_idx >= N_PIECES are ignored.
- cfg_ty  in  INT_BITS  shape type (0 tri, 1 square, 2 parallelogram).
- cfg_size  in  INT_BITS  shape size.
- cfg_sin  in  FLOAT_BITS  rotation sine, signed fixed-point.
- cfg_cos  in  FLOAT_BITS  rotation cosine, signed fixed-point.
- cfg_ix  in  FLOAT_BITS  start x, signed fixed-point.
- cfg_iy  in  FLOAT_BITS  start y, signed fixed-point.
- cfg_commit  in  1  request shadow→active copy at the next frame boundary.
- commit_pending  out  1  commit requested, not yet applied.
- commit_done  out  1  one-cycle pulse on the cycle the copy occurs.
- shp_newframe  out  1  to all shapes.
- shp_newline  out  1  to all shapes.
- shp_ty, shp_size  out  N_PIECES*INT_BITS  active bank, packed, piece 0 in LSBs.
- shp_sin, shp_cos, shp_ix, shp_iy  out  N_PIECES*FLOAT_BITS  active bank, packed.
- shp_hit  in  N_PIECES  render_shape out bits.
- pix_valid  out  1  registered; pixel is in the active area.
- pix_x  out  10  registered column.
- pix_y  out  10  registered row.
- pix_id  out  IDW  registered top piece covering the pixel; N_PIECES = background.

Behaviour:
- Counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1).
  - hc increments every cycle and wraps to 0, incrementing vc.
  - vc wraps to 0 after V_TOTAL-1.
- Reset: hc=H_TOTAL-1, vc=V_TOTAL-1, so the first cycle after reset issues newframe.
  - Both banks zeroed (size 0, nothing hits).
  - commit_pending=0, commit_done=0, pix_valid=0, pix_x=0, pix_y=0, pix_id=N_PIECES.
- shp_newframe is combinational: 1 iff hc==H_TOTAL-1 && vc==V_TOTAL-1.
- shp_newline is combinational: 1 iff hc==H_TOTAL-1 && vc<=V_ACTIVE-2. It is never high together with newframe.
- Result: render_shape's x/y corresponds to pixel (hc,vc) whenever hc<H_ACTIVE and vc<V_ACTIVE.
- Shadow write: cfg_we writes all six fields of shadow[cfg_idx] at the clock edge. Writes in any cycle are accepted and there is no backpressure.
- Commit:
  - cfg_commit sets commit_pending.
  - The swap point is the cycle with hc==H_TOTAL-2 && vc==V_TOTAL-1. If commit_pending is 1 there, active<=shadow for all pieces, commit_pending clears and commit_done pulses next cycle.
  - The new active values are therefore stable in the newframe cycle and for the whole frame.
- Swap-point boundary cases:
  - cfg_we on the swap cycle updates shadow only; the copy uses the pre-write shadow.
  - cfg_commit on the swap cycle leaves commit_pending=1 (re-armed for the next frame).
  - The active bank never changes mid-frame.
- Resolve, with 1-cycle latency:
  - pix_valid<=(hc<H_ACTIVE && vc<V_ACTIVE), pix_x<=hc, pix_y<=vc.
  - pix_id<=highest index i with shp_hit[i]=1 (highest index draws on top), else N_PIECES.
  - When not active, pix_id<=N_PIECES regardless of shp_hit.
- Reset mid-frame: counters, pending and outputs return to reset values next cycle. The active bank is cleared, so the next frame is blank.

Optional Feature:
- Macro: SHAPE_RENDER_SCHED_COVER_EN.
- Defined:
  - Adds output cover_count[19:0] and an internal accumulator.
  - The accumulator increments on every active pixel with any shp_hit bit set.
  - At the newframe cycle, cover_count<=accumulator and the accumulator clears.
  - Both reset to 0. cover_count is used for puzzle-completion checks.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset release -> shp_newframe=1 on the first cycle; next cycle pix counters start at (0,0); pix_valid first 1 one cycle later.
- Free-run one frame -> exactly 479 newline pulses and 1 newframe pulse per 800*525 cycles; pix_valid high for 640*480 cycles.
- Write piece 2 (ty=1, size=50, cos=1.0, sin=0, ix=iy=10.0) then commit mid-frame -> active unchanged until hc=798,vc=524; commit_done pulses; next frame shp_ix slice 2 = 10.0.
- shp_hit=7'b0010010 at an active pixel -> pix_id=4 next cycle; shp_hit=0 -> pix_id=7; hit during blanking -> pix_id=7, pix_valid=0.
- cfg_we and cfg_commit both on the swap cycle -> active gets the old shadow value; commit_pending stays 1; the new value lands one frame later.
- COVER_EN defined, 50x50 square fully on screen, other pieces size 0 -> cover_count=2500 after the following newframe.

Source files
------------

// File: rtl/shape_render_sched.sv
// shape_render_sched
//   Frame sequencer for a bank of N_PIECES render_shape instances.
//   - Raster counters (hc, vc) and the newframe/newline strobes that step the shapes.
//   - Double-buffered geometry: game logic writes the shadow bank. A commit copies
//     shadow to active on the cycle just before newframe, so the shapes see a
//     geometry set that stays constant for the whole frame.
//   - Resolves per-pixel coverage into a registered top-most piece ID.
//
// Ports
//   clk, rst                    pixel clock, synchronous active-high reset
//   cfg_we/cfg_idx/cfg_*        shadow-bank write of one piece (idx >= N_PIECES ignored)
//   cfg_commit                  request shadow->active copy at the next frame boundary
//   commit_pending/commit_done  commit status / one-cycle copy pulse
//   shp_newframe/shp_newline    combinational strobes to all shapes
//   shp_ty..shp_iy              active bank, packed, piece 0 in the LSBs
//   shp_hit                     per-piece coverage from the shapes
//   pix_valid/pix_x/pix_y/pix_id  registered pixel result (pix_id == N_PIECES: background)
//
// Optional build macro SHAPE_RENDER_SCHED_COVER_EN adds cover_count[19:0]: the number
// of covered active pixels in the previous frame.

module shape_render_sched #(
  parameter int N_PIECES   = 7,
  parameter int INT_BITS   = 10,
  parameter int FLOAT_BITS = 16,
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int IDW        = $clog2(N_PIECES + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_we,
  input  logic [IDW-1:0]                   cfg_idx,
  input  logic [INT_BITS-1:0]              cfg_ty,
  input  logic [INT_BITS-1:0]              cfg_size,
  input  logic [FLOAT_BITS-1:0]            cfg_sin,
  input  logic [FLOAT_BITS-1:0]            cfg_cos,
  input  logic [FLOAT_BITS-1:0]            cfg_ix,
  input  logic [FLOAT_BITS-1:0]            cfg_iy,
  input  logic                             cfg_commit,
  output logic                             commit_pending,
  output logic                             commit_done,
  output logic                             shp_newframe,
  output logic                             shp_newline,
  output logic [N_PIECES*INT_BITS-1:0]     shp_ty,
  output logic [N_PIECES*INT_BITS-1:0]     shp_size,
  output logic [N_PIECES*FLOAT_BITS-1:0]   shp_sin,
  output logic [N_PIECES*FLOAT_BITS-1:0]   shp_cos,
  output logic [N_PIECES*FLOAT_BITS-1:0]   shp_ix,
  output logic [N_PIECES*FLOAT_BITS-1:0]   shp_iy,
  input  logic [N_PIECES-1:0]              shp_hit,
  output logic                             pix_valid,
  output logic [9:0]                       pix_x,
  output logic [9:0]                       pix_y,
  output logic [IDW-1:0]                   pix_id
`ifdef SHAPE_RENDER_SCHED_COVER_EN
  ,
  output logic [19:0]                      cover_count
`endif
);

  localparam int HCW = $clog2(H_TOTAL);
  localparam int VCW = $clog2(V_TOTAL);
  localparam int IW  = N_PIECES * INT_BITS;
  localparam int FW  = N_PIECES * FLOAT_BITS;

  logic [HCW-1:0] r_hc;
  logic [VCW-1:0] r_vc;
  logic           w_hc_last;
  logic           w_vc_last;
  logic           w_active;
  logic           w_swap;
  logic [IDW-1:0] w_top;

  logic [IW-1:0]  r_sh_ty, r_sh_size, r_ac_ty, r_ac_size;
  logic [FW-1:0]  r_sh_sin, r_sh_cos, r_sh_ix, r_sh_iy;
  logic [FW-1:0]  r_ac_sin, r_ac_cos, r_ac_ix, r_ac_iy;
  logic           r_commit_pending;
  logic           r_commit_done;
  logic           r_pix_valid;
  logic [9:0]     r_pix_x;
  logic [9:0]     r_pix_y;
  logic [IDW-1:0] r_pix_id;

  assign w_hc_last = (r_hc == HCW'(H_TOTAL - 1));
  assign w_vc_last = (r_vc == VCW'(V_TOTAL - 1));
  assign w_active  = (r_hc < HCW'(H_ACTIVE)) && (r_vc < VCW'(V_ACTIVE));
  // One cycle before newframe: the copy lands exactly as the shapes restart.
  assign w_swap    = (r_hc == HCW'(H_TOTAL - 2)) && w_vc_last;

  assign shp_newframe = w_hc_last && w_vc_last;
  // No newline after the last active line: newframe restarts the shapes instead.
  assign shp_newline  = w_hc_last && (r_vc <= VCW'(V_ACTIVE - 2));

  // Raster counters; reset parks them on the last pixel so the first cycle is newframe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hc <= HCW'(H_TOTAL - 1);
      r_vc <= VCW'(V_TOTAL - 1);
    end else if (w_hc_last) begin
      r_hc <= '0;
      if (w_vc_last) begin
        r_vc <= '0;
      end else begin
        r_vc <= r_vc + VCW'(1);
      end
    end else begin
      r_hc <= r_hc + HCW'(1);
    end
  end

  // Shadow bank: one piece written per cfg_we, out-of-range indices match no slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_ty   <= '0;
      r_sh_size <= '0;
      r_sh_sin  <= '0;
      r_sh_cos  <= '0;
      r_sh_ix   <= '0;
      r_sh_iy   <= '0;
    end else begin
      for (int i = 0; i < N_PIECES; i++) begin
        if (cfg_we && (cfg_idx == IDW'(i))) begin
          r_sh_ty[i*INT_BITS +: INT_BITS]       <= cfg_ty;
          r_sh_size[i*INT_BITS +: INT_BITS]     <= cfg_size;
          r_sh_sin[i*FLOAT_BITS +: FLOAT_BITS]  <= cfg_sin;
          r_sh_cos[i*FLOAT_BITS +: FLOAT_BITS]  <= cfg_cos;
          r_sh_ix[i*FLOAT_BITS +: FLOAT_BITS]   <= cfg_ix;
          r_sh_iy[i*FLOAT_BITS +: FLOAT_BITS]   <= cfg_iy;
        end
      end
    end
  end

  // Active bank: copied from the pre-write shadow only at the swap point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ac_ty   <= '0;
      r_ac_size <= '0;
      r_ac_sin  <= '0;
      r_ac_cos  <= '0;
      r_ac_ix   <= '0;
      r_ac_iy   <= '0;
    end else if (w_swap && r_commit_pending) begin
      r_ac_ty   <= r_sh_ty;
      r_ac_size <= r_sh_size;
      r_ac_sin  <= r_sh_sin;
      r_ac_cos  <= r_sh_cos;
      r_ac_ix   <= r_sh_ix;
      r_ac_iy   <= r_sh_iy;
    end else begin
      r_ac_ty   <= r_ac_ty;
      r_ac_size <= r_ac_size;
      r_ac_sin  <= r_ac_sin;
      r_ac_cos  <= r_ac_cos;
      r_ac_ix   <= r_ac_ix;
      r_ac_iy   <= r_ac_iy;
    end
  end

  // Commit handshake; a new request on the swap cycle wins so it re-arms for next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit_pending <= 1'b0;
      r_commit_done    <= 1'b0;
    end else begin
      r_commit_done <= w_swap && r_commit_pending;
      if (cfg_commit) begin
        r_commit_pending <= 1'b1;
      end else if (w_swap) begin
        r_commit_pending <= 1'b0;
      end else begin
        r_commit_pending <= r_commit_pending;
      end
    end
  end

  // Highest hit index wins; the ascending scan leaves the last set bit.
  always_comb begin
    w_top = IDW'(N_PIECES);
    for (int i = 0; i < N_PIECES; i++) begin
      if (shp_hit[i]) begin
        w_top = IDW'(i);
      end else begin
        w_top = w_top;
      end
    end
  end

  // Pixel result register, one cycle behind the raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_valid <= 1'b0;
      r_pix_x     <= 10'd0;
      r_pix_y     <= 10'd0;
      r_pix_id    <= IDW'(N_PIECES);
    end else begin
      r_pix_valid <= w_active;
      r_pix_x     <= 10'(r_hc);
      r_pix_y     <= 10'(r_vc);
      r_pix_id    <= w_active ? w_top : IDW'(N_PIECES);
    end
  end

`ifdef SHAPE_RENDER_SCHED_COVER_EN
  logic [19:0] r_cover_acc;
  logic [19:0] r_cover_count;

  // Covered-pixel tally; published and cleared on the newframe cycle (never active).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cover_acc   <= 20'd0;
      r_cover_count <= 20'd0;
    end else if (shp_newframe) begin
      r_cover_count <= r_cover_acc;
      r_cover_acc   <= 20'd0;
    end else if (w_active && (|shp_hit)) begin
      r_cover_acc   <= r_cover_acc + 20'd1;
    end else begin
      r_cover_acc   <= r_cover_acc;
    end
  end

  assign cover_count = r_cover_count;
`endif

  assign commit_pending = r_commit_pending;
  assign commit_done    = r_commit_done;
  assign shp_ty         = r_ac_ty;
  assign shp_size       = r_ac_size;
  assign shp_sin        = r_ac_sin;
  assign shp_cos        = r_ac_cos;
  assign shp_ix         = r_ac_ix;
  assign shp_iy         = r_ac_iy;
  assign pix_valid      = r_pix_valid;
  assign pix_x          = r_pix_x;
  assign pix_y          = r_pix_y;
  assign pix_id         = r_pix_id;

endmodule

// File: tb/tb_shape_render_sched.sv
// Self-checking bench for shape_render_sched using a small raster so frames are short.
module tb_shape_render_sched;
  localparam int NP = 7, IB = 10, FB = 16, IDW = 3;
  localparam int HA = 16, HT = 20, VA = 12, VT = 15;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cfg_we, cfg_commit;
  logic [IDW-1:0] cfg_idx;
  logic [IB-1:0] cfg_ty, cfg_size;
  logic [FB-1:0] cfg_sin, cfg_cos, cfg_ix, cfg_iy;
  logic commit_pending, commit_done, shp_newframe, shp_newline;
  logic [NP*IB-1:0] shp_ty, shp_size;
  logic [NP*FB-1:0] shp_sin, shp_cos, shp_ix, shp_iy;
  logic [NP-1:0] shp_hit;
  logic pix_valid;
  logic [9:0] pix_x, pix_y;
  logic [IDW-1:0] pix_id;
`ifdef SHAPE_RENDER_SCHED_COVER_EN
  logic [19:0] cover_count;
`endif

  shape_render_sched #(.N_PIECES(NP), .INT_BITS(IB), .FLOAT_BITS(FB),
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_ty(cfg_ty),
    .cfg_size(cfg_size), .cfg_sin(cfg_sin), .cfg_cos(cfg_cos), .cfg_ix(cfg_ix),
    .cfg_iy(cfg_iy), .cfg_commit(cfg_commit), .commit_pending(commit_pending),
    .commit_done(commit_done), .shp_newframe(shp_newframe), .shp_newline(shp_newline),
    .shp_ty(shp_ty), .shp_size(shp_size), .shp_sin(shp_sin), .shp_cos(shp_cos),
    .shp_ix(shp_ix), .shp_iy(shp_iy), .shp_hit(shp_hit), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_id(pix_id)
`ifdef SHAPE_RENDER_SCHED_COVER_EN
    , .cover_count(cover_count)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: m_t counts cycles since the newframe cycle (t=0 is newframe).
  int m_t;
  logic [15:0] m_sh [6][NP];
  logic [15:0] m_ac [6][NP];
  bit m_pend, m_done, m_pv;
  int m_px, m_py, m_pid, m_acc, m_cov;
  bit chk_en = 1'b0;

  function automatic int hc_of(input int t);
    return ((t + FRAME - 1) % FRAME) % HT;
  endfunction
  function automatic int vc_of(input int t);
    return ((t + FRAME - 1) % FRAME) / HT;
  endfunction

  function automatic logic [127:0] pack(input int f, input int w);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < NP; i++)
      for (int b = 0; b < w; b++) v[i*w+b] = m_ac[f][i][b];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (time %0t)", nm, act, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs seen at that edge.
  task automatic model_step();
    int hc, vc, top;
    bit act, swap;
    hc = hc_of(m_t);
    vc = vc_of(m_t);
    if (rst) begin
      m_t = 0;
      for (int f = 0; f < 6; f++)
        for (int i = 0; i < NP; i++) begin m_sh[f][i] = '0; m_ac[f][i] = '0; end
      m_pend = 0; m_done = 0; m_pv = 0; m_px = 0; m_py = 0; m_pid = NP;
      m_acc = 0; m_cov = 0;
    end else begin
      act = (hc < HA) && (vc < VA);
      top = NP;
      for (int i = NP - 1; i >= 0; i--) if (shp_hit[i] && top == NP) top = i;
      m_pv = act; m_px = hc; m_py = vc; m_pid = act ? top : NP;
      swap = (hc == HT - 2) && (vc == VT - 1);
      m_done = swap && m_pend;
      if (m_done) m_ac = m_sh;
      if (cfg_commit) m_pend = 1; else if (swap) m_pend = 0;
      if (cfg_we && cfg_idx < NP) begin
        m_sh[0][cfg_idx] = 16'(cfg_ty);  m_sh[1][cfg_idx] = 16'(cfg_size);
        m_sh[2][cfg_idx] = cfg_sin;      m_sh[3][cfg_idx] = cfg_cos;
        m_sh[4][cfg_idx] = cfg_ix;       m_sh[5][cfg_idx] = cfg_iy;
      end
      if (hc == HT - 1 && vc == VT - 1) begin m_cov = m_acc; m_acc = 0; end
      else if (act && shp_hit != 0) m_acc++;
      m_t = (m_t + 1) % FRAME;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_to(input int target);
    for (int g = 0; g < FRAME && m_t != target; g++) cyc();
  endtask

  task automatic wr(input int idx, input int ty, input int sz, input int s, input int c,
                    input int x, input int y);
    cfg_we = 1'b1; cfg_idx = IDW'(idx); cfg_ty = IB'(ty); cfg_size = IB'(sz);
    cfg_sin = FB'(s); cfg_cos = FB'(c); cfg_ix = FB'(x); cfg_iy = FB'(y);
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    int hc, vc;
    if (chk_en) begin
      hc = hc_of(m_t);
      vc = vc_of(m_t);
      chk("newframe", shp_newframe, (hc == HT - 1 && vc == VT - 1));
      chk("newline", shp_newline, (hc == HT - 1 && vc <= VA - 2));
      chk("commit_pending", commit_pending, m_pend);
      chk("commit_done", commit_done, m_done);
      chk("pix_valid", pix_valid, m_pv);
      chk("pix_x", pix_x, m_px);
      chk("pix_y", pix_y, m_py);
      chk("pix_id", pix_id, m_pid);
      chk("shp_ty", shp_ty, pack(0, IB));
      chk("shp_size", shp_size, pack(1, IB));
      chk("shp_sin", shp_sin, pack(2, FB));
      chk("shp_cos", shp_cos, pack(3, FB));
      chk("shp_ix", shp_ix, pack(4, FB));
      chk("shp_iy", shp_iy, pack(5, FB));
`ifdef SHAPE_RENDER_SCHED_COVER_EN
      chk("cover_count", cover_count, m_cov);
`endif
    end
  end

  initial begin
    int nf, nl, npv;
    rst = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_idx = '0; cfg_ty = '0;
    cfg_size = '0; cfg_sin = '0; cfg_cos = '0; cfg_ix = '0; cfg_iy = '0; shp_hit = '0;
    repeat (3) cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_newframe", shp_newframe, 1);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_id", pix_id, 7);
    chk("rst_pix_xy", {pix_x, pix_y}, 0);

    // One free-running frame with random coverage.
    nf = 0; nl = 0; npv = 0;
    for (int k = 0; k < FRAME; k++) begin
      shp_hit = NP'($urandom);
      nf += int'(shp_newframe);
      nl += int'(shp_newline);
      cyc();
      npv += int'(pix_valid);
      if (k == 0) chk("first_valid_low", pix_valid, 0);
      if (k == 1) chk("first_valid_pix", {pix_valid, pix_x, pix_y}, {1'b1, 20'd0});
    end
    chk("frame_newframes", nf, 1);
    chk("frame_newlines", nl, VA - 1);
    chk("frame_valid_cycles", npv, HA * VA);
    shp_hit = '0;

    // Mid-frame write + commit of piece 2: lands only at the frame boundary.
    run_to(100);
    wr(2, 1, 50, 0, 16'h0100, 16'h0A00, 16'h0A00);
    cyc();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
    chk("commit_pending_set", commit_pending, 1);
    run_to(FRAME - 1);
    chk("pre_swap_ix2", shp_ix[47:32], 16'h0000);
    cyc();
    chk("swap_done", commit_done, 1);
    chk("swap_ix2", shp_ix[47:32], 16'h0A00);
    chk("swap_size2", shp_size[29:20], 10'd50);
    chk("swap_pending_clr", commit_pending, 0);

    // Piece-ID resolve at active and blanking pixels.
    run_to(44);                       // pixel (3,2)
    shp_hit = 7'b0010010;
    cyc();
    chk("hit_top", {pix_valid, pix_id}, {1'b1, 3'd4});
    chk("hit_xy", {pix_x, pix_y}, {10'd3, 10'd2});
    shp_hit = 7'b0000000;
    cyc();
    chk("hit_none", pix_id, 7);
    run_to(58);                       // pixel (17,2): horizontal blanking
    shp_hit = 7'b1111111;
    cyc();
    chk("hit_blank", {pix_valid, pix_id}, {1'b0, 3'd7});
    shp_hit = '0;

    // Write + commit on the swap cycle: copy takes the old shadow, re-arms.
    run_to(10);
    wr(2, 1, 50, 0, 16'h0100, 16'h0300, 16'h0A00);
    cfg_commit = 1'b1;
    cyc();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    run_to(FRAME - 1);
    wr(2, 1, 50, 0, 16'h0100, 16'h0500, 16'h0A00);
    cfg_commit = 1'b1;
    cyc();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    chk("bnd_old_value", shp_ix[47:32], 16'h0300);
    chk("bnd_pending", {commit_pending, commit_done}, 2'b11);
    run_to(FRAME - 1);
    cyc();
    chk("bnd_new_value", shp_ix[47:32], 16'h0500);
    chk("bnd_pending_clr", commit_pending, 0);

`ifdef SHAPE_RENDER_SCHED_COVER_EN
    rst = 1'b1; cyc(); rst = 1'b0;
    shp_hit = 7'b0000001;
    for (int k = 0; k < FRAME; k++) cyc();
    cyc();
    chk("cover_full_frame", cover_count, HA * VA);
    shp_hit = '0;
`endif

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      cfg_we = ($urandom % 4 == 0);
      cfg_idx = IDW'($urandom);
      cfg_ty = IB'($urandom % 3); cfg_size = IB'($urandom);
      cfg_sin = FB'($urandom); cfg_cos = FB'($urandom);
      cfg_ix = FB'($urandom); cfg_iy = FB'($urandom);
      cfg_commit = ($urandom % 150 == 0);
      case ($urandom % 4)
        0: shp_hit = '0;
        1: shp_hit = NP'(1 << ($urandom % NP));
        default: shp_hit = NP'($urandom);
      endcase
      rst = ($urandom % 1500 == 0);
      cyc();
    end
    rst = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
